log2_unit: RTL and testbench
============================

LOG2_UNIT -- requirements
Module: log2_unit

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; legal range 2..64.
REQ-002 Parameter: RW, default $clog2(WIDTH)+1, result width; fixed by WIDTH and never overridden.
REQ-003 Port: clk  input  1  single clock; all flops on rising edge.
REQ-004 Port: resetb  input  1  reset; asynchronous, active-low.
REQ-005 Port: start  input  1  request; sampled only in IDLE.
REQ-006 Port: mode  input  1  0 = floor(log2 N), 1 = ceil(log2 N); latched with N.
REQ-007 Port: N  input  WIDTH  operand; latched on an accepted start.
REQ-008 Port: R  output  RW  result register.
REQ-009 Port: done  output  1  one-cycle completion pulse.
REQ-010 Port: err  output  1  set when the accepted operand was zero.
REQ-011 Port: busy  output  1  high whenever state != IDLE (decoded from the state register).
REQ-012 Port: state  output  3  FSM state for observability: IDLE=3'b000, COMPUTE=3'b001, DONE=3'b010.

Function
REQ-013 Accept: start=1 in IDLE at edge E0 latches N into operand register t, latches mode, and clears count c and sticky bit s.
REQ-014 Accept: at E0 err is loaded with (N==0), and done is cleared.
REQ-015 Accept, N!=0: at E0 state goes IDLE->COMPUTE; R keeps its previous value throughout COMPUTE.
REQ-016 Accept, N==0: at E0 state goes IDLE->DONE, with done=1, err=1 and R=0; COMPUTE is skipped.
REQ-017 COMPUTE step: each cycle with t>1, t <= t>>1, c <= c+1 and s <= s | t[0].
REQ-018 COMPUTE finish: on the cycle with t<=1, R <= c + (mode & s), done <= 1 and state -> DONE.
REQ-019 Latency: for N!=0, done rises at edge E0+1+floor(log2 N); for N==0, at E0.
REQ-020 DONE: one cycle, then -> IDLE with done <= 0; done is never high for more than one cycle.
REQ-021 Hold: R and err hold their values from IDLE until the next accepted start.
REQ-022 Ceil rule: ceil equals floor plus 1 only when a 1 bit was shifted out (N not a power of two); for N=1, R=0 in both modes.
REQ-023 Width: c and R are RW bits wide and cannot overflow; the maximum result is WIDTH (ceil of all-ones).
REQ-024 Ignore: start is ignored in COMPUTE and DONE; N and mode changes after E0 have no effect on the result.
REQ-025 Restart: start held high continuously is accepted again on the first IDLE cycle after DONE.

Reset
REQ-026 resetb=0 asynchronously forces state=IDLE, R=0, done=0, err=0, c=0, s=0; t is also cleared.
REQ-027 Mid-operation: reset during COMPUTE or DONE aborts the operation with no done pulse; the first start after release is accepted normally.

Verification (WIDTH=16)
REQ-028 N=1, mode=0, start at E0 -> done at E0+1, R=0, err=0; state sequence 000,001,010,000.
REQ-029 N=40 -> mode=0 gives R=5 and mode=1 gives R=6; N=32 with mode=1 gives R=5; each done exactly one cycle wide.
REQ-030 N=16'hFFFF, mode=1 -> R=16 (5 bits) with done at E0+16; mode=0 -> R=15.
REQ-031 N=0 -> done and err at E0, R=0, no COMPUTE state; a following N=8 -> R=3 with err cleared at its accept.
REQ-032 Start pulsed with N=2 during COMPUTE of N=200 -> ignored; result R=7, busy high through DONE.
REQ-033 resetb low for one cycle mid-COMPUTE -> all outputs 0 and state 000 immediately, no done pulse; a new start with N=4 -> R=2.

Source files
------------

// File: rtl/log2_unit.sv
// Iterative floor/ceil log2: shifts the latched operand right one bit per cycle,
// counting shifts and remembering whether any 1 bit fell off the bottom.
module log2_unit #(
  parameter int WIDTH = 16,
  parameter int RW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] N,
  output logic [RW-1:0]    R,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [2:0]       state
);

  // Handshake: start is a request taken only in IDLE (no backpressure, no queueing);
  // done pulses for exactly one cycle and R/err are valid from that cycle until the next accept.
  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_COMPUTE = 3'b001,
    S_DONE    = 3'b010
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [RW-1:0]    c_q, c_d;
  logic [RW-1:0]    r_q, r_d;
  logic             s_q, s_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             more;
  logic             n_zero;

  assign more   = |t_q[WIDTH-1:1];
  assign n_zero = (N == '0);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = n_zero ? S_DONE : S_COMPUTE;
      S_COMPUTE: if (!more) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    state = state_q;
    R     = r_q;
    done  = done_q;
    err   = err_q;
  end

  always_comb begin
    t_d    = t_q;
    c_d    = c_q;
    r_d    = r_q;
    s_d    = s_q;
    mode_d = mode_q;
    done_d = done_q;
    err_d  = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          t_d    = N;
          mode_d = mode;
          c_d    = '0;
          s_d    = 1'b0;
          err_d  = n_zero;
          done_d = n_zero;
          if (n_zero) r_d = '0;
        end
      end
      S_COMPUTE: begin
        if (more) begin
          t_d = t_q >> 1;
          c_d = c_q + {{(RW-1){1'b0}}, 1'b1};
          s_d = s_q | t_q[0];
        end else begin
          // Ceil adds one only if a set bit was discarded, i.e. N was not a power of two.
          r_d    = c_q + {{(RW-1){1'b0}}, mode_q & s_q};
          done_d = 1'b1;
        end
      end
      S_DONE:  done_d = 1'b0;
      default: done_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      t_q    <= '0;
      c_q    <= '0;
      r_q    <= '0;
      s_q    <= 1'b0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      t_q    <= t_d;
      c_q    <= c_d;
      r_q    <= r_d;
      s_q    <= s_d;
      mode_q <= mode_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_log2_unit.sv
// Directed bench for log2_unit (WIDTH=16): hand-computed results and latencies,
// hold/ignore/restart behaviour and asynchronous reset mid-operation.
module tb_log2_unit;

  logic        clk = 1'b0;
  logic        resetb;
  logic        start;
  logic        mode;
  logic [15:0] N;
  logic [4:0]  R;
  logic        done;
  logic        err;
  logic        busy;
  logic [2:0]  state;

  int          errors = 0;
  int          checks = 0;
  logic [4:0]  last_r = '0;

  log2_unit #(.WIDTH(16)) dut (
    .clk    (clk),
    .resetb (resetb),
    .start  (start),
    .mode   (mode),
    .N      (N),
    .R      (R),
    .done   (done),
    .err    (err),
    .busy   (busy),
    .state  (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples 1 time unit after each rising edge until done, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [15:0] n, input logic m, input logic [4:0] exp_r,
                        input int exp_lat, input bit poke);
    int lat;
    bit hold_ok;
    bit busy_ok;
    @(negedge clk);
    start = 1'b1; N = n; mode = m;
    @(posedge clk); #1;
    start = 1'b0; N = 16'($urandom_range(0, 65535)); mode = ~m;
    check("accept_state", 32'(state), (n == 16'd0) ? 32'd2 : 32'd1);
    check("accept_err", 32'(err), 32'(n == 16'd0));
    lat = 0; hold_ok = 1'b1; busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (R !== last_r) hold_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (poke && lat == 2) begin
        start = 1'b1; N = 16'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("result", 32'(R), 32'(exp_r));
    check("done_state", 32'(state), 32'd2);
    check("done_busy", 32'(busy), 32'd1);
    check("done_err", 32'(err), 32'(n == 16'd0));
    check("r_hold_compute", 32'(hold_ok), 32'd1);
    check("busy_compute", 32'(busy_ok), 32'd1);
    last_r = exp_r;
    @(posedge clk); #1;
    check("done_pulse_width", 32'(done), 32'd0);
    check("back_idle", 32'(state), 32'd0);
    check("r_hold_idle", 32'(R), 32'(exp_r));
  endtask

  initial begin
    int lat;
    int seen;
    resetb = 1'b0; start = 1'b0; mode = 1'b0; N = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_r", 32'(R), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    @(negedge clk); resetb = 1'b1;

    run_op(16'd1,      1'b0, 5'd0,  1,  1'b0);
    run_op(16'd40,     1'b0, 5'd5,  6,  1'b0);
    run_op(16'd40,     1'b1, 5'd6,  6,  1'b0);
    run_op(16'd32,     1'b1, 5'd5,  6,  1'b0);
    run_op(16'hFFFF,   1'b1, 5'd16, 16, 1'b0);
    run_op(16'hFFFF,   1'b0, 5'd15, 16, 1'b0);
    run_op(16'd0,      1'b1, 5'd0,  0,  1'b0);
    run_op(16'd8,      1'b0, 5'd3,  4,  1'b0);
    run_op(16'd200,    1'b0, 5'd7,  8,  1'b1);

    // start held high: re-accepted on the first IDLE cycle after DONE
    @(negedge clk); start = 1'b1; N = 16'd5; mode = 1'b0;
    @(posedge clk); #1;
    wait_done(lat);
    check("restart_first_lat", 32'(lat), 32'd3);
    check("restart_first_r", 32'(R), 32'd2);
    N = 16'd6;
    @(posedge clk); #1;
    check("restart_idle", 32'(state), 32'd0);
    @(posedge clk); #1;
    check("restart_accept", 32'(state), 32'd1);
    start = 1'b0;
    wait_done(lat);
    check("restart_second_lat", 32'(lat), 32'd3);
    check("restart_second_r", 32'(R), 32'd2);
    last_r = 5'd2;
    @(posedge clk); #1;

    // asynchronous reset in the middle of COMPUTE
    @(negedge clk); start = 1'b1; N = 16'd200; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetb = 1'b0;
    #1;
    check("midrst_r", 32'(R), 32'd0);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    @(negedge clk); resetb = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    last_r = 5'd0;
    run_op(16'd4, 1'b0, 5'd2, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
